alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the generated combinational ALUs.
- Registers operands and opcode, computes result and flags, then holds them in an output register.
- Uses valid/ready handshakes on both sides, with full throughput and backpressure.
- Sits between the operand-issue logic and the writeback/consumer stage of the datapath.

---
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 tb/tb_alu_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers operands, S2 registers result and flags.
// Optional sticky {overflow, carry} accumulator enabled by ALU_PIPE_STICKY_FLAGS_EN.
module alu_pipe #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    input  logic [SHAMT_W-1:0] shiftValue,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carryFlag,
    output logic               overflowFlag,
    output logic               zeroFlag,
    output logic               signFlag,
    output logic               illegalOp
`ifdef ALU_PIPE_STICKY_FLAGS_EN
    ,
    input  logic               sticky_clr,
    output logic [1:0]         sticky_flags
`endif
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLL   = 4'd4,
        OP_SEQ   = 4'd5,
        OP_PASSB = 4'd6,
        OP_NAND  = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_XOR   = 4'd10,
        OP_SLT   = 4'd11
    } op_e;

    localparam int M = WIDTH - 1;

    logic               r_s1_valid;
    logic [3:0]         r_s1_op;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic [SHAMT_W-1:0] r_s1_sh;

    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;
    logic               r_sign;
    logic               r_ill;

    logic               w_s2_adv;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic               w_ill;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_sh    <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= opcode;
                r_s1_a  <= input1;
                r_s1_b  <= input2;
                r_s1_sh <= shiftValue;
            end
        end
    end

    always_comb begin
        w_add   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
        w_sub   = {1'b0, r_s1_a} - {1'b0, r_s1_b};
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_ill   = 1'b0;
        case (r_s1_op)
            OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (r_s1_a[M] == r_s1_b[M]) && (w_add[M] != r_s1_a[M]);
            end
            OP_SUB: begin
                // the extra sum bit is the unsigned borrow
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (r_s1_a[M] != r_s1_b[M]) && (w_sub[M] != r_s1_a[M]);
            end
            OP_AND:   w_res = r_s1_a & r_s1_b;
            OP_OR:    w_res = r_s1_a | r_s1_b;
            OP_SLL:   w_res = r_s1_a << r_s1_sh;
            OP_SEQ:   w_res = {{(WIDTH-1){1'b0}}, (r_s1_a == r_s1_b)};
            OP_PASSB: w_res = r_s1_b;
            OP_NAND:  w_res = ~(r_s1_a & r_s1_b);
            OP_SRL:   w_res = r_s1_a >> r_s1_sh;
            OP_SRA:   w_res = $unsigned($signed(r_s1_a) >>> r_s1_sh);
            OP_XOR:   w_res = r_s1_a ^ r_s1_b;
            OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
            default:  w_ill = 1'b1;
        endcase
    end

    // S2 keeps its last values whenever no new beat arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_sign     <= 1'b0;
            r_ill      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_carry  <= w_carry;
                r_ovf    <= w_ovf;
                r_zero   <= (w_res == '0);
                r_sign   <= w_res[M];
                r_ill    <= w_ill;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign result       = r_result;
    assign carryFlag    = r_carry;
    assign overflowFlag = r_ovf;
    assign zeroFlag     = r_zero;
    assign signFlag     = r_sign;
    assign illegalOp    = r_ill;

`ifdef ALU_PIPE_STICKY_FLAGS_EN
    logic [1:0] r_sticky;

    always_ff @(posedge clk) begin
        if (rst || sticky_clr) begin
            r_sticky <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_sticky <= r_sticky | {r_ovf, r_carry};
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=64): opcodes, stall/stream, flush
// and, when ALU_PIPE_STICKY_FLAGS_EN is defined, the sticky flag register.
module tb_alu_pipe;

    localparam int WIDTH   = 64;
    localparam int SHAMT_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         opcode;
    logic [WIDTH-1:0]   input1;
    logic [WIDTH-1:0]   input2;
    logic [SHAMT_W-1:0] shiftValue;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               carryFlag;
    logic               overflowFlag;
    logic               zeroFlag;
    logic               signFlag;
    logic               illegalOp;
`ifdef ALU_PIPE_STICKY_FLAGS_EN
    logic               sticky_clr;
    logic [1:0]         sticky_flags;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .input1       (input1),
        .input2       (input2),
        .shiftValue   (shiftValue),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .carryFlag    (carryFlag),
        .overflowFlag (overflowFlag),
        .zeroFlag     (zeroFlag),
        .signFlag     (signFlag),
        .illegalOp    (illegalOp)
`ifdef ALU_PIPE_STICKY_FLAGS_EN
        ,
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic        flush_mon = 1'b0;
    int          flush_seen = 0;
    logic [63:0] got_q[$];
    int          cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            got_q.push_back(result);
            cyc_q.push_back(cyc);
        end
        if (flush_mon && out_valid) flush_seen <= flush_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one beat into an empty pipeline with out_ready=1; result is visible
    // two edges after the drive point and is delivered on the following edge.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [5:0] sh, input logic [63:0] res,
                           input logic c, input logic o, input logic z, input logic s,
                           input logic ill);
        opcode = op; input1 = a; input2 = b; shiftValue = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".v1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, ".v2"}, 64'(out_valid), 64'd1);
        check({tag, ".res"}, result, res);
        check({tag, ".flg"}, 64'({carryFlag, overflowFlag, zeroFlag, signFlag, illegalOp}),
              64'({c, o, z, s, ill}));
        @(posedge clk); #1;
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; input1 = '0; input2 = '0; shiftValue = '0;
`ifdef ALU_PIPE_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst.ov", 64'(out_valid), 64'd0);
        check("rst.ir", 64'(in_ready), 64'd1);
        check("rst.res", result, 64'd0);
        check("rst.flg", 64'({carryFlag, overflowFlag, zeroFlag, signFlag, illegalOp}), 64'd0);

        //      tag      op     A                       B           sh  result                  c o z s ill
        run_vec("add_c",  4'd0,  ONES,                   64'd1,      0, 64'd0,                  1,0,1,0,0);
        run_vec("sub_v",  4'd1,  MSB,                    64'd1,      0, 64'h7FFF_FFFF_FFFF_FFFF,0,1,0,0,0);
        run_vec("sub_b",  4'd1,  64'd3,                  64'd5,      0, 64'hFFFF_FFFF_FFFF_FFFE,1,0,0,1,0);
        run_vec("add_v",  4'd0,  64'h7FFF_FFFF_FFFF_FFFF,64'd1,      0, MSB,                    0,1,0,1,0);
        run_vec("sra63",  4'd9,  MSB,                    64'd0,     63, ONES,                   0,0,0,1,0);
        run_vec("sll63",  4'd4,  64'd1,                  64'd0,     63, MSB,                    0,0,0,1,0);
        run_vec("srl63",  4'd8,  MSB,                    64'd0,     63, 64'd1,                  0,0,0,0,0);
        run_vec("sll0",   4'd4,  64'h1234,               64'd0,      0, 64'h1234,               0,0,0,0,0);
        run_vec("seq",    4'd5,  64'd5,                  64'd5,      0, 64'd1,                  0,0,0,0,0);
        run_vec("slt",    4'd11, ONES,                   64'd0,      0, 64'd1,                  0,0,0,0,0);
        run_vec("and",    4'd2,  64'hF0F0,               64'hFF00,   0, 64'hF000,               0,0,0,0,0);
        run_vec("or",     4'd3,  64'hF0F0,               64'h0F00,   0, 64'hFFF0,               0,0,0,0,0);
        run_vec("nand",   4'd7,  64'd0,                  64'd0,      0, ONES,                   0,0,0,1,0);
        run_vec("xor",    4'd10, 64'hFF,                 64'hFF,     0, 64'd0,                  0,0,1,0,0);
        run_vec("passb",  4'd6,  64'd7,                  64'hABCD,   0, 64'hABCD,               0,0,0,0,0);
        run_vec("ill13",  4'd13, 64'd9,                  64'd9,      0, 64'd0,                  0,0,1,0,1);

        // Stream 6 ADD beats with the consumer stalled for the first cycles
        mon_en = 1'b1;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic acc;
                    opcode = 4'd0; input1 = 64'(i + 10); input2 = 64'(3 * i); in_valid = 1'b1;
                    acc = 1'b0;
                    for (int t = 0; t < 30 && !acc; t++) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                    end
                    if (!acc) check("strm.accept", 64'd0, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check("stall.ir", 64'(in_ready), 64'd0);
                check("stall.ov", 64'(out_valid), 64'd1);
                check("stall.res0", result, 64'd10);
                repeat (3) @(posedge clk);
                #1;
                check("stall.ir2", 64'(in_ready), 64'd0);
                check("stall.res1", result, 64'd10);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 40 && got_q.size() < 6; t++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("strm.count", 64'(got_q.size()), 64'd6);
        if (got_q.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("strm.res%0d", i), got_q[i], 64'(4 * i + 10));
            check("strm.span", 64'(cyc_q[5] - cyc_q[0]), 64'd5);
        end

        // Reset with two beats in flight
        out_ready = 1'b0;
        opcode = 4'd0; input1 = 64'h111; input2 = 64'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        input1 = 64'h222;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("flush.ov", 64'(out_valid), 64'd0);
        check("flush.ir", 64'(in_ready), 64'd1);
        check("flush.res", result, 64'd0);
        out_ready = 1'b1;
        flush_mon = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        flush_mon = 1'b0;
        check("flush.none", 64'(flush_seen), 64'd0);

`ifdef ALU_PIPE_STICKY_FLAGS_EN
        check("stk.rst", 64'(sticky_flags), 64'd0);
        run_vec("stk_add", 4'd0, ONES, 64'd1, 0, 64'd0, 1,0,1,0,0);
        run_vec("stk_and", 4'd2, 64'd3, 64'd1, 0, 64'd1, 0,0,0,0,0);
        check("stk.hold", 64'(sticky_flags), 64'd1);
        opcode = 4'd0; input1 = ONES; input2 = 64'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stk.ov", 64'(out_valid), 64'd1);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check("stk.clr", 64'(sticky_flags), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
